// File: rtl/alu_defs.sv
// Shared ALU definitions: operand width, counter width and multiplier FSM encodings.
`default_nettype none
package alu_defs;
  localparam int N_BITS = 32;
  localparam int CNT_W  = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage
`default_nettype wire

// File: rtl/Adder32bit.sv
// 32-bit combinational adder with sum-is-zero flag; carry-out is recovered by the caller.
`default_nettype none
module Adder32bit
  import alu_defs::*;
(
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  input  logic              Cin,
  output logic [N_BITS-1:0] S,
  output logic              Z
);
  assign S = A + B + {{(N_BITS-1){1'b0}}, Cin};
  assign Z = ~|S;
endmodule
`default_nettype wire

// File: rtl/mul_seq_u32.sv
// Unsigned 32x32->64 shift-add multiplier: one partial-product add per clock through Adder32bit.
`default_nettype none
module mul_seq_u32
  import alu_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_BITS-1:0]   a,
  input  logic [N_BITS-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*N_BITS-1:0] p,
  output logic                zero
);
  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [N_BITS-1:0]   m;
  logic [N_BITS-1:0]   hi;
  logic [N_BITS-1:0]   lo;
  logic [N_BITS-1:0]   add_b;
  logic [N_BITS-1:0]   add_s;
  logic                add_c;
  logic                add_z_unused;
  logic [2*N_BITS-1:0] p_reg;
  logic                zero_reg;

  assign add_b = lo[0] ? m : '0;

  Adder32bit u_add (
    .A   (hi),
    .B   (add_b),
    .Cin (1'b0),
    .S   (add_s),
    .Z   (add_z_unused)
  );

  // Adder has no carry-out; rebuild it from the operand and sum MSBs.
  assign add_c = (hi[N_BITS-1] & add_b[N_BITS-1]) |
                 ((hi[N_BITS-1] | add_b[N_BITS-1]) & ~add_s[N_BITS-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      m        <= '0;
      hi       <= '0;
      lo       <= '0;
      p_reg    <= '0;
      zero_reg <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m     <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          {hi, lo} <= {add_c, add_s, lo[N_BITS-1:1]};
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(N_BITS - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          p_reg    <= {hi, lo};
          zero_reg <= ~|{hi, lo};
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // In DONE the product is forwarded straight from HI/LO so it is valid alongside done.
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign p    = done ? {hi, lo} : p_reg;
  assign zero = done ? ~|{hi, lo} : zero_reg;
endmodule
`default_nettype wire

// File: tb/tb_mul_seq_u32.sv
// Directed scoreboard bench for mul_seq_u32.
`default_nettype none
module tb_mul_seq_u32;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] p;
  logic        zero;

  int vectors;
  int miscompares;
  logic [63:0] exp_q[$];

  mul_seq_u32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive start for one accepting edge; returns at the negedge after acceptance.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input bit push);
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) exp_q.push_back(64'(av) * 64'(bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      chk1("done_timeout", done, 1'b1);
    end
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chkint({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk64({tag, "_p"}, p, e);
      chk1({tag, "_zero"}, zero, (e == 64'd0));
    end
  endtask

  initial begin
    int cyc;
    int t_done[3];
    int n_done;
    logic saw_done;
    logic [63:0] held;

    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk64("rst_p", p, 64'd0);
    chk1("rst_zero", zero, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // 1: 3*5 with latency and busy checks
    start_op(32'd3, 32'd5, 1'b1);
    chk1("t1_busy_run", busy, 1'b1);
    wait_done(cyc);
    chkint("t1_latency", cyc, 32);
    check_result("t1");
    @(negedge clk);
    chk1("t1_done_fell", done, 1'b0);
    chk1("t1_busy_low", busy, 1'b0);
    chk64("t1_p_held", p, 64'h0F);

    // 2: all-ones operands
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc);
    check_result("t2");
    @(negedge clk);

    // 3: zero operands
    start_op(32'd0, 32'h1234_5678, 1'b1);
    wait_done(cyc);
    check_result("t3a");
    @(negedge clk);
    start_op(32'h8000_0000, 32'd0, 1'b1);
    wait_done(cyc);
    check_result("t3b");
    @(negedge clk);

    // 4: start while busy is ignored and new a/b do not disturb the op
    start_op(32'h8000_0000, 32'd2, 1'b1);
    repeat (9) @(negedge clk);
    a     = 32'd7;
    b     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chkint("t4_latency", cyc + 10, 32);
    check_result("t4");
    held     = p;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk1("t4_no_extra_done", saw_done, 1'b0);
    chk64("t4_p_held", p, 64'h1_0000_0000);
    chk64("t4_p_stable", p, held);

    // 5: reset mid-run aborts, then the same operands run cleanly
    start_op(32'd9, 32'd9, 1'b0);
    saw_done = 1'b0;
    repeat (14) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("t5_abort_busy", busy, 1'b0);
    chk64("t5_abort_p", p, 64'd0);
    chk1("t5_abort_zero", zero, 1'b1);
    repeat (40) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk1("t5_no_done", saw_done, 1'b0);
    start_op(32'd9, 32'd9, 1'b1);
    wait_done(cyc);
    chkint("t5_latency", cyc, 32);
    check_result("t5");
    @(negedge clk);

    // 6: back-to-back with start held high
    a     = 32'd10;
    b     = 32'd10;
    start = 1'b1;
    exp_q.push_back(64'd100);
    n_done = 0;
    cyc    = 0;
    while (n_done < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        t_done[n_done] = cyc;
        check_result($sformatf("t6_op%0d", n_done));
        n_done++;
        if (n_done == 1) begin
          a = 32'h8000_0000;
          b = 32'h8000_0000;
          exp_q.push_back(64'(a) * 64'(b));
        end else if (n_done == 2) begin
          a = 32'd1;
          b = 32'd1;
          exp_q.push_back(64'd1);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chkint("t6_done_count", n_done, 3);
    if (n_done == 3) begin
      chkint("t6_gap1", t_done[1] - t_done[0], 34);
      chkint("t6_gap2", t_done[2] - t_done[1], 34);
    end
    @(negedge clk);
    chk64("t6_p_held", p, 64'd1);
    chkint("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
